// File: rtl/ram_sdp_be.sv
// Simple-dual-port block RAM with per-byte write enables, selectable collision
// behaviour, optional output register and a built-in fill-with-constant sequencer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | user reads/writes accepted; a pending start or i_clear enters CLEAR
// ST_CLEAR | one CLEAR_VALUE write per cycle at clr_cnt; user ports ignored
module ram_sdp_be #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int OUT_REG        = 0,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_clear,
  output logic                             o_busy,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wr_be,
  input  logic                             i_rd_en,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_valid
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            state;
  logic                  start_pend;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic                  user_wr;
  logic                  rd_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_BYTES-1:0]  mem_wbe;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Auto-clear is held as a pending start so o_busy stays low through reset
  // and rises on the first cycle after release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      start_pend <= (CLEAR_ON_RESET != 0);
      clr_cnt    <= '0;
    end else if (state == ST_IDLE) begin
      start_pend <= 1'b0;
      if (start_pend || i_clear) begin
        state   <= ST_CLEAR;
        clr_cnt <= '0;
      end
    end else begin
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
        state <= ST_IDLE;
      end
    end
  end

  assign o_busy  = (state == ST_CLEAR);
  assign user_wr = i_wr_en && !o_busy && !i_reset;
  assign rd_acc  = i_rd_en && !o_busy && !i_reset;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_wr_addr;
    mem_wdata = i_wr_data;
    mem_wbe   = i_wr_be;
    if (o_busy) begin
      mem_we    = !i_reset;
      mem_waddr = clr_cnt;
      mem_wdata = CLEAR_VALUE;
      mem_wbe   = '1;
    end else begin
      mem_we    = user_wr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (mem_wbe[k]) begin
          mem[mem_waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Write-first forwards only the enabled lanes; the rest come from the array.
  always_comb begin
    rd_word = mem[i_rd_addr];
    if ((WRITE_FIRST != 0) && user_wr && (i_wr_addr == i_rd_addr)) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (i_wr_be[k]) begin
          rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = i_wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          s1_valid   <= 1'b0;
          s1_data    <= '0;
          o_rd_valid <= 1'b0;
          o_rd_data  <= '0;
        end else begin
          s1_valid   <= rd_acc;
          o_rd_valid <= s1_valid;
          if (rd_acc) begin
            s1_data <= rd_word;
          end
          if (s1_valid) begin
            o_rd_data <= s1_data;
          end
        end
      end
    end else begin : g_no_out_reg
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          o_rd_valid <= 1'b0;
          o_rd_data  <= '0;
        end else begin
          o_rd_valid <= rd_acc;
          if (rd_acc) begin
            o_rd_data <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench: two instances share stimulus; dut_a is read-first/1-cycle,
// dut_b is write-first/2-cycle, both 16-deep with CLEAR_VALUE 16'hA5A5.
module tb_ram_sdp_be;

  logic        i_clk;
  logic        i_reset;
  logic        i_clear;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [15:0] i_wr_data;
  logic [1:0]  i_wr_be;
  logic        i_rd_en;
  logic [3:0]  i_rd_addr;

  logic        busy_a, busy_b;
  logic [15:0] data_a, data_b;
  logic        valid_a, valid_b;

  int n_checks = 0;
  int n_errors = 0;

  ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .OUT_REG(0),
               .WRITE_FIRST(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .o_busy(busy_a),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_be(i_wr_be),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(data_a), .o_rd_valid(valid_a)
  );

  ram_sdp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .OUT_REG(1),
               .WRITE_FIRST(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .o_busy(busy_b),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_be(i_wr_be),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(data_b), .o_rd_valid(valid_b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
    i_wr_en   = 1'b1;
    i_wr_addr = addr;
    i_wr_data = data;
    i_wr_be   = be;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic rd_single(input string tag, input logic [3:0] addr,
                           input logic [15:0] exp_a, input logic [15:0] exp_b);
    i_rd_en   = 1'b1;
    i_rd_addr = addr;
    tick();
    i_rd_en   = 1'b0;
    check_val({tag, "_valid_a"}, 32'(valid_a), 32'd1);
    check_val({tag, "_data_a"}, 32'(data_a), 32'(exp_a));
    check_val({tag, "_early_b"}, 32'(valid_b), 32'd0);
    tick();
    check_val({tag, "_valid_b"}, 32'(valid_b), 32'd1);
    check_val({tag, "_data_b"}, 32'(data_b), 32'(exp_b));
    check_val({tag, "_late_a"}, 32'(valid_a), 32'd0);
  endtask

  task automatic count_busy(output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy_a) ca++;
      if (busy_b) cb++;
    end
  endtask

  int ca, cb;

  initial begin
    i_reset = 1'b1; i_clear = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0;
    i_wr_data = '0; i_wr_be = '0; i_rd_en = 1'b0; i_rd_addr = '0;
    repeat (3) tick();
    check_val("rst_busy_a", 32'(busy_a), 32'd0);
    check_val("rst_busy_b", 32'(busy_b), 32'd0);
    check_val("rst_valid_a", 32'(valid_a), 32'd0);
    check_val("rst_valid_b", 32'(valid_b), 32'd0);
    check_val("rst_data_a", 32'(data_a), 32'd0);
    check_val("rst_data_b", 32'(data_b), 32'd0);

    // Auto clear after reset release
    i_reset = 1'b0;
    tick();
    check_val("busy_rise_a", 32'(busy_a), 32'd1);
    count_busy(ca, cb);
    check_val("auto_clr_len_a", 32'(ca + 1), 32'd16);
    check_val("auto_clr_len_b", 32'(cb + 1), 32'd16);

    // Back-to-back reads of every address; dut_b lags one cycle
    for (int i = 0; i < 16; i++) begin
      i_rd_en   = 1'b1;
      i_rd_addr = 4'(i);
      tick();
      check_val("burst_valid_a", 32'(valid_a), 32'd1);
      check_val("burst_data_a", 32'(data_a), 32'hA5A5);
      if (i > 0) begin
        check_val("burst_valid_b", 32'(valid_b), 32'd1);
        check_val("burst_data_b", 32'(data_b), 32'hA5A5);
      end
    end
    i_rd_en = 1'b0;
    tick();
    check_val("burst_end_a", 32'(valid_a), 32'd0);
    check_val("burst_last_b", 32'(valid_b), 32'd1);
    check_val("burst_last_data_b", 32'(data_b), 32'hA5A5);
    tick();
    check_val("burst_end_b", 32'(valid_b), 32'd0);

    // Byte enables
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hFFEE, 2'b01);
    rd_single("be_lo", 4'd3, 16'h12EE, 16'h12EE);
    wr(4'd3, 16'h5555, 2'b00);
    rd_single("be_none", 4'd3, 16'h12EE, 16'h12EE);
    wr(4'd3, 16'h77AA, 2'b10);
    rd_single("be_hi", 4'd3, 16'h77EE, 16'h77EE);

    // Full-word collision
    wr(4'd5, 16'h0001, 2'b11);
    i_wr_en = 1'b1; i_wr_addr = 4'd5; i_wr_data = 16'hBEEF; i_wr_be = 2'b11;
    i_rd_en = 1'b1; i_rd_addr = 4'd5;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    check_val("coll_rf_a", 32'(data_a), 32'h0001);
    tick();
    check_val("coll_wf_b", 32'(data_b), 32'hBEEF);
    rd_single("coll_after", 4'd5, 16'hBEEF, 16'hBEEF);

    // Partial-lane collision: write-first merges new low byte with old high byte
    i_wr_en = 1'b1; i_wr_addr = 4'd5; i_wr_data = 16'h1122; i_wr_be = 2'b01;
    i_rd_en = 1'b1; i_rd_addr = 4'd5;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    check_val("pcoll_rf_a", 32'(data_a), 32'hBEEF);
    tick();
    check_val("pcoll_wf_b", 32'(data_b), 32'hBE22);
    rd_single("pcoll_after", 4'd5, 16'hBE22, 16'hBE22);

    // Ordered burst with distinct data, then hold
    wr(4'd0, 16'h1111, 2'b11);
    wr(4'd1, 16'h2222, 2'b11);
    wr(4'd2, 16'h3333, 2'b11);
    i_rd_en = 1'b1; i_rd_addr = 4'd0;
    tick();
    check_val("ord0_a", 32'(data_a), 32'h1111);
    check_val("ord0_nv_b", 32'(valid_b), 32'd0);
    i_rd_addr = 4'd1;
    tick();
    check_val("ord1_a", 32'(data_a), 32'h2222);
    check_val("ord0_b", 32'({valid_b, data_b}), 32'h11111);
    i_rd_addr = 4'd2;
    tick();
    check_val("ord2_a", 32'(data_a), 32'h3333);
    check_val("ord1_b", 32'({valid_b, data_b}), 32'h12222);
    i_rd_en = 1'b0;
    tick();
    check_val("hold_a", 32'({valid_a, data_a}), 32'h03333);
    check_val("ord2_b", 32'({valid_b, data_b}), 32'h13333);
    tick();
    check_val("hold_b", 32'({valid_b, data_b}), 32'h03333);
    check_val("hold2_a", 32'({valid_a, data_a}), 32'h03333);

    // Clear pulse with user traffic and a second pulse during the sequence
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    ca = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy_a) ca++;
      i_wr_en = busy_a; i_wr_addr = 4'd0; i_wr_data = 16'hDEAD; i_wr_be = 2'b11;
      i_rd_en = busy_a; i_rd_addr = 4'd0;
      i_clear = (i == 5);
      tick();
      check_val("clr_no_valid_a", 32'(valid_a), 32'd0);
      check_val("clr_no_valid_b", 32'(valid_b), 32'd0);
    end
    i_wr_en = 1'b0; i_rd_en = 1'b0; i_clear = 1'b0;
    check_val("clr_len", 32'(ca), 32'd16);
    rd_single("clr_addr0", 4'd0, 16'hA5A5, 16'hA5A5);
    rd_single("clr_addr3", 4'd3, 16'hA5A5, 16'hA5A5);

    // Reset aborting a clear at cycle 7
    wr(4'd9, 16'h7777, 2'b11);
    rd_single("pre_abort", 4'd9, 16'h7777, 16'h7777);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    repeat (7) tick();
    check_val("abort_busy_pre", 32'(busy_a), 32'd1);
    i_reset = 1'b1;
    tick();
    check_val("abort_busy_a", 32'(busy_a), 32'd0);
    check_val("abort_busy_b", 32'(busy_b), 32'd0);
    tick();
    check_val("abort_busy2_a", 32'(busy_a), 32'd0);
    i_reset = 1'b0;
    count_busy(ca, cb);
    check_val("reclr_len_a", 32'(ca), 32'd16);
    check_val("reclr_len_b", 32'(cb), 32'd16);
    rd_single("reclr_addr9", 4'd9, 16'hA5A5, 16'hA5A5);
    rd_single("reclr_addr15", 4'd15, 16'hA5A5, 16'hA5A5);
    rd_single("reclr_addr5", 4'd5, 16'hA5A5, 16'hA5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
Parametrised simple-dual-port synchronous RAM. It has one write port with per-byte write enables and one independent read port. It adds a selectable read-during-write collision mode, an optional output pipeline register with a read-valid strobe, and a built-in clear sequencer that fills the whole array with a constant. It is the general-purpose block-RAM primitive for frame buffers, FIFOs and lookup tables on the iCE40 designs, and maps to EBR.

Parameters:
ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
WRITE_FIRST, 0, 0 = read-first on address collision; 1 = write-first (new data forwarded).
CLEAR_ON_RESET, 1, 1 = clear sequence starts automatically when reset deasserts.
CLEAR_VALUE, 0, DATA_WIDTH-wide word written to every location during clear.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_clear  in  1  single-cycle pulse that starts a clear sequence; ignored while o_busy=1.
o_busy  out  1  high while the clear sequence runs.
i_wr_en  in  1  write request.
i_wr_addr  in  ADDR_WIDTH  write address.
i_wr_data  in  DATA_WIDTH  write data.
i_wr_be  in  NUM_BYTES  byte enables; bit k covers data bits [k*BYTE_WIDTH +: BYTE_WIDTH].
i_rd_en  in  1  read request.
i_rd_addr  in  ADDR_WIDTH  read address.
o_rd_data  out  DATA_WIDTH  read data; holds its last value when no read completes.
o_rd_valid  out  1  one-cycle strobe marking o_rd_data as new.

Behaviour:
- Reset is synchronous and active-high.
  - On reset: o_rd_data=0, o_rd_valid=0, all pipeline valid bits=0, clear counter=0.
  - Array contents are not modified by reset itself.
  - State after reset: CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - o_busy=0 while i_reset=1.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on i_clear=1, or on the first cycle after reset when CLEAR_ON_RESET=1.
  - CLEAR writes CLEAR_VALUE to addr = counter each cycle, then counter+1.
  - CLEAR -> IDLE after address 2**ADDR_WIDTH-1 is written. The sequence takes exactly 2**ADDR_WIDTH cycles.
  - o_busy=1 in every CLEAR cycle and is registered, so it rises the cycle after the trigger.
- During CLEAR:
  - i_wr_en and i_rd_en are ignored; no user write occurs and no o_rd_valid is issued.
  - i_clear is ignored.
- Reset during CLEAR aborts the sequence. It restarts from address 0 if CLEAR_ON_RESET=1, otherwise goes to IDLE with the array partially cleared.
- Write, in IDLE with i_wr_en=1: for each k with i_wr_be[k]=1, lane k of mem[i_wr_addr] takes lane k of i_wr_data. Other lanes are unchanged. i_wr_be=0 means no change.
- Read, in IDLE with i_rd_en=1:
  - OUT_REG=0: o_rd_data = mem[i_rd_addr] on the next edge, o_rd_valid=1 for that one cycle.
  - OUT_REG=1: data and valid appear one cycle later.
  - Back-to-back reads give one result per cycle, in order.
- Collision, i_wr_en & i_rd_en & (i_wr_addr == i_rd_addr) in the same cycle:
  - WRITE_FIRST=0: read returns the pre-write word.
  - WRITE_FIRST=1: read returns the merged word (enabled lanes new, other lanes old).
- A read issued in the last CLEAR cycle is dropped. A read in the first IDLE cycle returns CLEAR_VALUE.
- o_rd_data holds its value when no read completes; it is not zeroed after the valid strobe.
- Any pipeline stage still in flight when CLEAR starts completes normally.
- Address wrap: none; all addresses are in range by construction.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=16'hA5A5 -> o_busy high for exactly 16 cycles; then reads of addresses 0..15 all return 16'hA5A5 with o_rd_valid one cycle after each i_rd_en (OUT_REG=0).
- Write 16'h1234 to addr 3 with be=2'b11, then 16'hFFEE with be=2'b01 -> read addr 3 returns 16'h12EE; a write with be=2'b00 leaves 16'h12EE.
- Collision, addr 5 holding 16'h0001: write 16'hBEEF be=2'b11 and read addr 5 in the same cycle -> WRITE_FIRST=0 returns 16'h0001, WRITE_FIRST=1 returns 16'hBEEF; the next read returns 16'hBEEF in both modes.
- OUT_REG=1: read bursts of addresses 0,1,2 on consecutive cycles -> o_rd_valid high on cycles +2, +3, +4 with matching data. With i_rd_en low, o_rd_data holds the addr-2 value.
- i_clear pulse in IDLE; i_wr_en to addr 0 and i_rd_en during CLEAR -> no write lands, no o_rd_valid; afterwards addr 0 reads CLEAR_VALUE. A second i_clear mid-sequence does not extend o_busy past 16 cycles.
- i_reset asserted at CLEAR cycle 7 -> o_busy=0 during reset; after release a full 16-cycle clear runs and all addresses read CLEAR_VALUE.
